// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register with a 2-entry skid buffer (main + skid).
// Carries one write-back bundle per entry across a valid/ready boundary, with flush to bubble.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2,
  parameter int RD_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [1:0]        count_o
);

  localparam int ENT_W = CTRL_W + 2 * DATA_W + RD_W;

  // Encoding equals the occupancy, so count_o is the state register itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q;
  logic [ENT_W-1:0]   main_q;
  logic [ENT_W-1:0]   skid_q;
  logic [ENT_W-1:0]   in_bundle;
  logic               acc;
  logic               drn;

  assign in_bundle   = {ctrl_i, rdata_i, alu_i, rd_i};
  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign acc         = in_valid_i & in_ready_o;
  assign drn         = out_valid_o & out_ready_i;
  assign count_o     = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      state_q <= EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            main_q  <= in_bundle;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (acc && drn) begin
            main_q <= in_bundle;
          end else if (acc) begin
            skid_q  <= in_bundle;
            state_q <= FULL;
          end else if (drn) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (drn) begin
            main_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  // An empty stage must never assert RegWrite; data fields keep their last value.
  assign ctrl_o  = main_q[ENT_W-1 -: CTRL_W] & {CTRL_W{out_valid_o}};
  assign rdata_o = main_q[RD_W + DATA_W +: DATA_W];
  assign alu_o   = main_q[RD_W +: DATA_W];
  assign rd_o    = main_q[RD_W-1:0];

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed testbench for pipe_stage_skid: reset, streaming, back-pressure, flush,
// bubble ctrl gating and mid-stream reset, each checked against hand-computed values.
module tb_pipe_stage_skid;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  ctrl_i;
  logic [31:0] rdata_i;
  logic [31:0] alu_i;
  logic [4:0]  rd_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [1:0]  ctrl_o;
  logic [31:0] rdata_o;
  logic [31:0] alu_o;
  logic [4:0]  rd_o;
  logic [1:0]  count_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(2), .RD_W(5)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .ctrl_i      (ctrl_i),
    .rdata_i     (rdata_i),
    .alu_i       (alu_i),
    .rd_i        (rd_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .ctrl_o      (ctrl_o),
    .rdata_o     (rdata_o),
    .alu_o       (alu_o),
    .rd_o        (rd_o),
    .count_o     (count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle outputs 1 time unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] rdat,
                       input logic [31:0] alu, input logic [4:0] rd);
    in_valid_i = v;
    ctrl_i     = c;
    rdata_i    = rdat;
    alu_i      = alu;
    rd_i       = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    drive(1'b1, 2'b11, 32'hDEAD, 32'hBEEF, 5'd9);

    // Reset: the handshake presented during reset is ignored.
    step();
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_ctrl",  32'(ctrl_o),      32'd0);
    check("rst_rdata", rdata_o,          32'd0);
    check("rst_alu",   alu_o,            32'd0);
    check("rst_rd",    32'(rd_o),        32'd0);
    check("rst_count", 32'(count_o),     32'd0);
    rst_i = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    check("rst_ready", 32'(in_ready_o),  32'd1);

    // Single bundle, one-cycle latency.
    out_ready_i = 1'b1;
    drive(1'b1, 2'b10, 32'h11, 32'h22, 5'd5);
    step();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    check("s1_valid", 32'(out_valid_o), 32'd1);
    check("s1_ctrl",  32'(ctrl_o),      32'd2);
    check("s1_rdata", rdata_o,          32'h11);
    check("s1_alu",   alu_o,            32'h22);
    check("s1_rd",    32'(rd_o),        32'd5);
    check("s1_count", 32'(count_o),     32'd1);
    step();
    check("s1_empty", 32'(out_valid_o), 32'd0);
    check("s1_gate",  32'(ctrl_o),      32'd0);
    check("s1_keep",  alu_o,            32'h22);

    // Back-pressure: A and B absorbed, C refused until space frees up.
    out_ready_i = 1'b0;
    drive(1'b1, 2'b10, 32'h0, 32'hA, 5'd1);
    check("bp_rdyA", 32'(in_ready_o), 32'd1);
    step();
    drive(1'b1, 2'b10, 32'h0, 32'hB, 5'd2);
    check("bp_rdyB", 32'(in_ready_o), 32'd1);
    step();
    drive(1'b1, 2'b10, 32'h0, 32'hC, 5'd3);
    check("bp_rdyC", 32'(in_ready_o), 32'd0);
    check("bp_cnt2", 32'(count_o),    32'd2);
    check("bp_headA", alu_o,          32'hA);
    step();
    check("bp_hold", 32'(count_o),    32'd2);
    check("bp_holdA", alu_o,          32'hA);
    out_ready_i = 1'b1;
    step();
    check("bp_outB", alu_o,           32'hB);
    check("bp_cntB", 32'(count_o),    32'd1);
    check("bp_rdyB2", 32'(in_ready_o), 32'd1);
    step();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    check("bp_outC", alu_o,           32'hC);
    check("bp_rdC",  32'(rd_o),       32'd3);
    check("bp_cntC", 32'(count_o),    32'd1);
    step();
    check("bp_drain", 32'(count_o),   32'd0);

    // Sustained throughput.
    out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'b10, 32'h0, 32'(i), 5'd4);
      check("tp_ready", 32'(in_ready_o), 32'd1);
      step();
      check("tp_valid", 32'(out_valid_o), 32'd1);
      check("tp_alu",   alu_o,            32'(i));
      check("tp_count", 32'(count_o),     32'd1);
    end
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    step();
    check("tp_end", 32'(count_o), 32'd0);

    // Flush while FULL with a simultaneous input.
    out_ready_i = 1'b0;
    drive(1'b1, 2'b10, 32'h0, 32'h31, 5'd6);
    step();
    drive(1'b1, 2'b10, 32'h0, 32'h32, 5'd7);
    step();
    check("fl_full", 32'(count_o), 32'd2);
    flush_i = 1'b1;
    drive(1'b1, 2'b11, 32'h0, 32'h99, 5'd8);
    step();
    flush_i = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    check("fl_valid", 32'(out_valid_o), 32'd0);
    check("fl_ctrl",  32'(ctrl_o),      32'd0);
    check("fl_count", 32'(count_o),     32'd0);
    check("fl_keep",  alu_o,            32'h31);
    out_ready_i = 1'b1;
    step();
    check("fl_no99",  32'(out_valid_o), 32'd0);
    check("fl_alu",   alu_o,            32'h31);

    // Bubble control gating after draining ctrl=11.
    drive(1'b1, 2'b11, 32'h0, 32'h55, 5'd10);
    step();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    check("bg_ctrl", 32'(ctrl_o), 32'd3);
    step();
    check("bg_gate",  32'(ctrl_o),      32'd0);
    check("bg_valid", 32'(out_valid_o), 32'd0);
    check("bg_alu",   alu_o,            32'h55);

    // Reset mid-stream with out_ready_i toggling.
    out_ready_i = 1'b0;
    drive(1'b1, 2'b10, 32'h7, 32'h71, 5'd11);
    step();
    out_ready_i = 1'b1;
    drive(1'b1, 2'b10, 32'h7, 32'h72, 5'd12);
    step();
    out_ready_i = 1'b0;
    drive(1'b1, 2'b10, 32'h7, 32'h73, 5'd13);
    step();
    check("mr_pre", 32'(count_o), 32'd2);
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    drive(1'b1, 2'b10, 32'h7, 32'h74, 5'd14);
    step();
    rst_i = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    check("mr_count", 32'(count_o),     32'd0);
    check("mr_valid", 32'(out_valid_o), 32'd0);
    check("mr_alu",   alu_o,            32'd0);
    check("mr_rdata", rdata_o,          32'd0);
    check("mr_rd",    32'(rd_o),        32'd0);
    drive(1'b1, 2'b01, 32'h8, 32'h75, 5'd15);
    step();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    check("mr_first", alu_o,            32'h75);
    check("mr_fctrl", 32'(ctrl_o),      32'd1);
    check("mr_fvld",  32'(out_valid_o), 32'd1);
    step();
    check("mr_empty", 32'(count_o),     32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
